// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, flush to NOP and a saturating stall counter.
// Define PIPE_STAGE_SKID_EN for the two-entry skid buffer with a registered in_ready.
module pipe_stage_reg #(
    parameter int                DATA_W    = 64,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              outValid_q, outValid_d;
    logic [DATA_W-1:0] outData_q, outData_d;
    logic [CNT_W-1:0]  stallCnt_q, stallCnt_d;
    logic              inFire;
    logic              mainLoad;

    assign inFire    = in_valid && in_ready;
    assign mainLoad  = !outValid_q || out_ready;
    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign stall_cnt = stallCnt_q;

    // Back-pressure counter uses the pre-flush valid, so flush cycles still count.
    always_comb begin
        stallCnt_d = stallCnt_q;
        if (outValid_q && !out_ready && (stallCnt_q != {CNT_W{1'b1}})) begin
            stallCnt_d = stallCnt_q + CNT_W'(1);
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    logic              skidValid_q, skidValid_d;
    logic [DATA_W-1:0] skidData_q, skidData_d;

    // in_ready comes straight from a flop, so upstream never sees out_ready combinationally.
    assign in_ready = !skidValid_q;

    always_comb begin
        outValid_d  = outValid_q;
        outData_d   = outData_q;
        skidValid_d = skidValid_q;
        skidData_d  = skidData_q;
        if (flush) begin
            outValid_d  = 1'b0;
            outData_d   = RESET_VAL;
            skidValid_d = 1'b0;
        end else if (mainLoad) begin
            if (skidValid_q) begin
                outValid_d  = 1'b1;
                outData_d   = skidData_q;
                skidValid_d = 1'b0;
            end else if (inFire) begin
                outValid_d = 1'b1;
                outData_d  = in_data;
            end else begin
                outValid_d = 1'b0;
            end
        end else if (inFire) begin
            skidValid_d = 1'b1;
            skidData_d  = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            skidValid_q <= 1'b0;
            skidData_q  <= RESET_VAL;
        end else begin
            skidValid_q <= skidValid_d;
            skidData_q  <= skidData_d;
        end
    end
`else
    assign in_ready = mainLoad;

    always_comb begin
        outValid_d = outValid_q;
        outData_d  = outData_q;
        if (flush) begin
            outValid_d = 1'b0;
            outData_d  = RESET_VAL;
        end else if (inFire) begin
            outValid_d = 1'b1;
            outData_d  = in_data;
        end else if (out_ready) begin
            outValid_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            outValid_q <= 1'b0;
            outData_q  <= RESET_VAL;
            stallCnt_q <= '0;
        end else begin
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
            stallCnt_q <= stallCnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised scoreboard bench for pipe_stage_reg; a second instance with CNT_W=3 covers counter saturation.
// Works for both builds of PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_data;
    logic [15:0] stall_cnt;

    logic        sInValid = 1'b0;
    logic        sInReady;
    logic [7:0]  sInData = '0;
    logic        sOutValid;
    logic        sOutReady = 1'b1;
    logic [7:0]  sOutData;
    logic [2:0]  sStallCnt;

    int          nCompared = 0;
    int          nMismatched = 0;
    logic [63:0] sbq[$];
    logic [63:0] lastData = '0;
    logic [15:0] stallExp = '0;
    logic        monEn = 1'b0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(64), .RESET_VAL(64'h0), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(.DATA_W(8), .RESET_VAL(8'h0), .CNT_W(3)) satDut (
        .clk(clk), .reset(reset), .flush(1'b0),
        .in_valid(sInValid), .in_ready(sInReady), .in_data(sInData),
        .out_valid(sOutValid), .out_ready(sOutReady), .out_data(sOutData),
        .stall_cnt(sStallCnt)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the stage holds exactly the accepted, not yet consumed payloads; capacity decides readiness.
    task automatic applyStimulus(input logic v, input logic [63:0] d, input logic ordy,
                                 input logic fl, output logic accepted);
        int   cnt;
        logic expReady;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        cnt = sbq.size();
`ifdef PIPE_STAGE_SKID_EN
        expReady = (cnt < 2);
`else
        expReady = (cnt == 0) || ordy;
`endif
        accepted = v && expReady;
        #2;
        checkOutput("in_ready", {63'b0, in_ready}, {63'b0, expReady});
        checkOutput("stall_cnt", {48'b0, stall_cnt}, {48'b0, stallExp});
        @(posedge clk);
        if (cnt > 0 && !ordy && stallExp != 16'hFFFF) stallExp++;
        if (fl) begin
            sbq.delete();
            lastData = '0;
        end else begin
            if (accepted) sbq.push_back(d);
            if (sbq.size() > 0) lastData = sbq[0];
        end
    endtask

    task automatic resetDut();
        monEn = 1'b0;
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        flush    = 1'b0;
        repeat (2) @(posedge clk);
        sbq.delete();
        lastData = '0;
        stallExp = '0;
        monEn    = 1'b1;
        #1 reset = 1'b0;
    endtask

    // Offer one payload, holding it until the model says it was taken (bounded).
    task automatic offer(input logic [63:0] d, input logic ordy);
        logic acc;
        acc = 1'b0;
        for (int t = 0; t < 8 && !acc; t++) applyStimulus(1'b1, d, ordy, 1'b0, acc);
    endtask

    always @(negedge clk) begin
        if (monEn) begin
            logic expV;
            #1;
            expV = (sbq.size() > 0);
            checkOutput("out_valid", {63'b0, out_valid}, {63'b0, expV});
            if (expV) begin
                checkOutput("out_data", out_data, sbq[0]);
                if (out_ready) void'(sbq.pop_front());
            end else begin
                checkOutput("out_data_idle", out_data, lastData);
            end
        end
    end

    initial begin
        logic acc;
        resetDut();

        // Streaming 1..8 with downstream always ready.
        for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 64'(i), 1'b1, 1'b0, acc);
        repeat (2) applyStimulus(1'b0, '0, 1'b1, 1'b0, acc);

        // Back-pressure: offer A, B, C while downstream stalls, then release.
        applyStimulus(1'b1, 64'hA, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 64'hB, 1'b0, 1'b0, acc);
        repeat (3) applyStimulus(1'b1, 64'hC, 1'b0, 1'b0, acc);
        offer(64'hC, 1'b1);
        repeat (4) applyStimulus(1'b0, '0, 1'b1, 1'b0, acc);

        // Fill the stage, then flush with a same-cycle offer of 0xD.
        offer(64'h11, 1'b0);
        applyStimulus(1'b1, 64'h22, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 64'hD, 1'b0, 1'b1, acc);
        repeat (3) applyStimulus(1'b0, '0, 1'b1, 1'b0, acc);

        // Randomised traffic with occasional flushes and one mid-run reset.
        for (int c = 0; c < 600; c++) begin
            if (c == 300) resetDut();
            applyStimulus(($urandom % 4) != 0, {$urandom, $urandom},
                          ($urandom % 10) < 6, ($urandom % 32) == 0, acc);
        end
        repeat (3) applyStimulus(1'b0, '0, 1'b1, 1'b0, acc);

        // Saturation on the 3-bit counter instance while the main instance idles.
        fork
            begin
                logic acc2;
                repeat (13) applyStimulus(1'b0, '0, 1'b1, 1'b0, acc2);
            end
            begin
                @(negedge clk);
                sInValid  = 1'b1;
                sInData   = 8'h5A;
                sOutReady = 1'b0;
                @(negedge clk);
                sInValid = 1'b0;
                #1;
                checkOutput("sat_stall_start", {61'b0, sStallCnt}, 64'd0);
                repeat (10) @(negedge clk);
                #1;
                checkOutput("sat_stall_cnt", {61'b0, sStallCnt}, 64'd7);
                checkOutput("sat_out_valid", {63'b0, sOutValid}, 64'd1);
                checkOutput("sat_out_data", {56'b0, sOutData}, 64'h5A);
                sOutReady = 1'b1;
            end
        join

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
